wb_arbiter_2m: RTL
==================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT, default 255; slave-wait cycles before a transfer is aborted with err (range 2..65535).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 (data bus) cycle, strobe and write-enable.
REQ-005 m0_sel_i  input  4  master 0 byte select.
REQ-006 m0_addr_i, m0_data_i  input  32 each  master 0 address and write data.
REQ-007 m0_data_o  output  32  master 0 read data.
REQ-008 m0_ack_o, m0_err_o  output  1 each  master 0 acknowledge and timeout error.
REQ-009 m1_* ports identical to REQ-004..REQ-008 for master 1 (instruction bus).
REQ-010 s_cyc_o, s_stb_o, s_we_o  output  1 each  shared bus cycle, strobe and write-enable toward the bus decoder.
REQ-011 s_sel_o  output  4; s_addr_o, s_data_o  output  32 each  shared bus select, address and write data.
REQ-012 s_data_i  input  32; s_ack_i  input  1  shared bus read data and acknowledge.
REQ-013 grant_o  output  2  one-hot current grant {m1,m0}; 00 when idle.

Function
REQ-014 FSM states IDLE, GRANT0, GRANT1; state register plus a 1-bit last-served pointer (lp) and a 16-bit wait counter (wcnt).
REQ-015 IDLE: only m0_cyc_i -> GRANT0; only m1_cyc_i -> GRANT1; both -> grant to master not equal to lp (round-robin); neither -> stay IDLE.
REQ-016 Grant is registered: a master asserting cyc in IDLE sees s_cyc_o driven on the following cycle (1-cycle arbitration latency).
REQ-017 GRANTx: s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_addr_o/s_data_o combinationally follow master x; other master's request held off (no ack, no err).
REQ-018 GRANTx: mx_ack_o = s_ack_i and mx_data_o = s_data_i combinationally; non-granted master ack=0, data=0.
REQ-019 Grant held across multiple stb/ack beats while mx_cyc_i stays high (bus lock for back-to-back transfers).
REQ-020 GRANTx -> IDLE on the cycle mx_cyc_i is sampled low; lp <= x at that transition; one IDLE cycle always separates two grants.
REQ-021 IDLE: all s_* outputs 0, all master acks/errs 0, all master data_o 0, grant_o 00.
REQ-022 wcnt clears in IDLE and on any cycle s_ack_i=1 or granted stb=0; otherwise increments while granted stb=1.
REQ-023 wcnt reaching TIMEOUT-1 with no ack: next cycle mx_err_o=1 for exactly one cycle, s_cyc_o/s_stb_o forced 0 that cycle, wcnt cleared, state -> IDLE, lp <= x.
REQ-024 s_ack_i arriving in the same cycle wcnt reaches TIMEOUT-1: ack wins, no err.
REQ-025 s_ack_i while IDLE is ignored (no master ack).
REQ-026 Master dropping cyc mid-wait (before ack): release per REQ-020, no err, wcnt cleared.
REQ-027 Wait counter saturates; never wraps.

Reset
REQ-028 rst low asynchronously forces state IDLE, lp=1 (so m0 wins the first simultaneous request), wcnt=0, and all outputs to the IDLE values of REQ-021, regardless of any transfer in progress.
REQ-029 Transfer in progress at reset is discarded; no ack or err is produced for it after rst returns high.

Verification
REQ-030 After reset, m0 and m1 raise cyc/stb same cycle -> next cycle grant_o=01, s_addr_o=m0_addr_i; slave ack after 2 cycles -> m0_ack_o=1 that cycle, m1_ack_o=0.
REQ-031 Both masters continuously requesting, single-beat transfers -> grants alternate 01,00,10,00,01...; no master granted twice in a row.
REQ-032 m1 holds cyc for 4 reads, slave acks each in 1 cycle, m0 requests mid-burst -> grant stays 10 for all 4 beats, then 00, then 01.
REQ-033 TIMEOUT=4, m0 read, slave never acks -> m0_err_o=1 exactly on the 5th cycle after grant, s_cyc_o=0 that cycle, grant_o=00 next.
REQ-034 m0 write 0xDEADBEEF sel=1111 to 0x0000_1000, rst pulsed low mid-wait -> all s_* outputs 0 immediately, no ack/err after release, next request granted normally.
REQ-035 s_ack_i pulsed while IDLE -> m0_ack_o and m1_ack_o remain 0, state unchanged.

Source files
------------

// File: rtl/wb_arbiter_2m_if.sv
// Signal bundle between two Wishbone masters, the arbiter and the shared bus.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding logic (masters plus bus decoder) that drives the arbiter.
interface wb_arbiter_2m_if;
    // Master 0 (data bus)
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic        m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_data_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;
    logic        m0_err_o;
    // Master 1 (instruction bus)
    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic        m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_data_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;
    logic        m1_err_o;
    // Shared bus toward the decoder
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_data_o;
    logic [31:0] s_data_i;
    logic        s_ack_i;
    // One-hot grant {m1,m0}
    logic [1:0]  grant_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
        output m0_data_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
        output m1_data_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
        input  s_data_i, s_ack_i,
        output grant_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
        input  m0_data_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
        input  m1_data_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
        output s_data_i, s_ack_i,
        input  grant_o
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter with registered round-robin grant, bus lock
// while the granted master holds cyc, and a slave-wait timeout that aborts
// the transfer with a one-cycle err pulse.
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    wb_arbiter_2m_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_lp;          // last master served (1 = m1)
    logic        w_lp_nxt;
    logic [15:0] r_wcnt;        // consecutive slave-wait cycles
    logic [15:0] w_wcnt_nxt;
    logic        r_to;          // timeout abort cycle in progress
    logic        w_to_nxt;
    logic        w_cyc;         // granted master's cyc
    logic        w_stb;         // granted master's stb

    assign w_cyc = (r_state == GRANT1) ? bus.m1_cyc_i : bus.m0_cyc_i;
    assign w_stb = (r_state == GRANT1) ? bus.m1_stb_i : bus.m0_stb_i;

    // State, round-robin pointer, wait counter and abort flag registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_lp    <= 1'b1;    // m0 wins the first simultaneous request
            r_wcnt  <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lp    <= w_lp_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_to    <= w_to_nxt;
        end
    end

    // Next-state: arbitration in IDLE, release/timeout/wait counting when granted.
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_lp_nxt    = r_lp;
        w_wcnt_nxt  = r_wcnt;
        w_to_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_wcnt_nxt = '0;
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    w_state_nxt = r_lp ? GRANT0 : GRANT1;
                end else if (bus.m0_cyc_i) begin
                    w_state_nxt = GRANT0;
                end else if (bus.m1_cyc_i) begin
                    w_state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (r_to || !w_cyc) begin
                    // Abort cycle finished or master released the bus
                    w_state_nxt = IDLE;
                    w_lp_nxt    = (r_state == GRANT1);
                    w_wcnt_nxt  = '0;
                end else if (bus.s_ack_i || !w_stb) begin
                    // An ack on the last allowed wait cycle still wins
                    w_wcnt_nxt = '0;
                end else if (r_wcnt == WAIT_LIMIT) begin
                    w_to_nxt   = 1'b1;
                    w_wcnt_nxt = '0;
                end else if (r_wcnt != 16'hFFFF) begin
                    w_wcnt_nxt = r_wcnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output mux: route the granted master to the shared bus and back.
    always_comb begin
        bus.s_cyc_o   = 1'b0;
        bus.s_stb_o   = 1'b0;
        bus.s_we_o    = 1'b0;
        bus.s_sel_o   = '0;
        bus.s_addr_o  = '0;
        bus.s_data_o  = '0;
        bus.m0_ack_o  = 1'b0;
        bus.m0_err_o  = 1'b0;
        bus.m0_data_o = '0;
        bus.m1_ack_o  = 1'b0;
        bus.m1_err_o  = 1'b0;
        bus.m1_data_o = '0;
        bus.grant_o   = 2'b00;
        case (r_state)
            GRANT0: begin
                bus.s_cyc_o   = bus.m0_cyc_i & ~r_to;
                bus.s_stb_o   = bus.m0_stb_i & ~r_to;
                bus.s_we_o    = bus.m0_we_i;
                bus.s_sel_o   = bus.m0_sel_i;
                bus.s_addr_o  = bus.m0_addr_i;
                bus.s_data_o  = bus.m0_data_i;
                bus.m0_ack_o  = bus.s_ack_i & ~r_to;
                bus.m0_err_o  = r_to;
                bus.m0_data_o = bus.s_data_i;
                bus.grant_o   = 2'b01;
            end
            GRANT1: begin
                bus.s_cyc_o   = bus.m1_cyc_i & ~r_to;
                bus.s_stb_o   = bus.m1_stb_i & ~r_to;
                bus.s_we_o    = bus.m1_we_i;
                bus.s_sel_o   = bus.m1_sel_i;
                bus.s_addr_o  = bus.m1_addr_i;
                bus.s_data_o  = bus.m1_data_i;
                bus.m1_ack_o  = bus.s_ack_i & ~r_to;
                bus.m1_err_o  = r_to;
                bus.m1_data_o = bus.s_data_i;
                bus.grant_o   = 2'b10;
            end
            default: ;
        endcase
    end

endmodule
